pp3_mult_acc: RTL

- Parametrised, pipelined multiply-accumulate unit for PP3 soft-logic datapaths. It generalises the fixed 16x16 signed multiplier wrapper.
- Configurable operand widths, per-operation signed/unsigned mode, and an optional accumulator with sticky overflow.
- Valid/ready handshake on both sides; a downstream stall freezes the whole pipeline.
- Sits between DSP-style producers and consumers; the multiply itself is left to synthesis.

---
 rtl/pp3_mult_acc.sv | 132 +++++++++++++
 1 files changed

// File: rtl/pp3_mult_acc.sv
// Pipelined multiply-accumulate with valid/ready handshake and sticky overflow.
// The product is formed at the input, carried down the pipe, and accumulated in the last stage.
module pp3_mult_acc #(
    parameter int A_WIDTH     = 16,
    parameter int B_WIDTH     = 16,
    parameter int ACC_WIDTH   = 40,
    parameter int PIPE_STAGES = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [A_WIDTH-1:0]   Amult,
    input  logic [B_WIDTH-1:0]   Bmult,
    input  logic                 Signed,
    input  logic                 Acc_en,
    input  logic                 Acc_clr,
    input  logic                 Valid_in,
    output logic                 Ready_out,
    output logic [ACC_WIDTH-1:0] Cmult,
    output logic                 Valid_out,
    input  logic                 Ready_in,
    output logic                 Ovf
);

    localparam int PW   = A_WIDTH + B_WIDTH;
    localparam int NREG = (PIPE_STAGES > 1) ? PIPE_STAGES - 1 : 1;
    localparam logic [ACC_WIDTH-1:0] EXT_MASK = {ACC_WIDTH{1'b1}} << PW;

    if (A_WIDTH < 2 || A_WIDTH > 32) begin : g_bad_a
        $error("pp3_mult_acc: A_WIDTH must be in 2..32");
    end
    if (B_WIDTH < 2 || B_WIDTH > 32) begin : g_bad_b
        $error("pp3_mult_acc: B_WIDTH must be in 2..32");
    end
    if (ACC_WIDTH < PW) begin : g_bad_acc
        $error("pp3_mult_acc: ACC_WIDTH must be >= A_WIDTH+B_WIDTH");
    end
    if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_pipe
        $error("pp3_mult_acc: PIPE_STAGES must be in 1..4");
    end

    typedef struct packed {
        logic                 vld;
        logic                 sgn;
        logic                 acc_en;
        logic                 acc_clr;
        logic [ACC_WIDTH-1:0] prod;
    } op_t;

    logic                 advance;
    logic [PW-1:0]        a_ext;
    logic [PW-1:0]        b_ext;
    logic [PW-1:0]        prod_raw;
    op_t                  op_in;
    op_t                  op_head;
    logic [ACC_WIDTH-1:0] acc_q;
    logic [ACC_WIDTH:0]   sum;
    logic                 add_ovf;

    assign advance   = !(Valid_out && !Ready_in);
    assign Ready_out = advance;

    // Extending both operands to the full product width makes one multiply serve both modes.
    always_comb begin
        a_ext          = {{B_WIDTH{Signed & Amult[A_WIDTH-1]}}, Amult};
        b_ext          = {{A_WIDTH{Signed & Bmult[B_WIDTH-1]}}, Bmult};
        prod_raw       = a_ext * b_ext;
        op_in.vld      = Valid_in;
        op_in.sgn      = Signed;
        op_in.acc_en   = Acc_en;
        op_in.acc_clr  = Acc_clr;
        op_in.prod     = ACC_WIDTH'(prod_raw) |
                         ((Signed && prod_raw[PW-1]) ? EXT_MASK : '0);
    end

    if (PIPE_STAGES > 1) begin : g_pipe
        op_t stage_q [NREG];

        always_ff @(posedge CLK) begin
            if (RST) begin
                for (int i = 0; i < NREG; i++) begin
                    stage_q[i] <= '0;
                end
            end else if (advance) begin
                stage_q[0] <= op_in;
                for (int i = 1; i < NREG; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign op_head = stage_q[NREG-1];
    end else begin : g_nopipe
        assign op_head = op_in;
    end

    always_comb begin
        sum     = {1'b0, acc_q} + {1'b0, op_head.prod};
        add_ovf = 1'b0;
        if (op_head.sgn) begin
            add_ovf = (acc_q[ACC_WIDTH-1] == op_head.prod[ACC_WIDTH-1]) &&
                      (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
        end else begin
            add_ovf = sum[ACC_WIDTH];
        end
    end

    // Final stage reads acc_q written on the previous edge, so back-to-back adds chain.
    always_ff @(posedge CLK) begin
        if (RST) begin
            acc_q     <= '0;
            Cmult     <= '0;
            Valid_out <= 1'b0;
            Ovf       <= 1'b0;
        end else if (advance) begin
            Valid_out <= op_head.vld;
            if (op_head.vld) begin
                if (!op_head.acc_en) begin
                    Cmult <= op_head.prod;
                end else if (op_head.acc_clr) begin
                    acc_q <= op_head.prod;
                    Cmult <= op_head.prod;
                    Ovf   <= 1'b0;
                end else begin
                    acc_q <= sum[ACC_WIDTH-1:0];
                    Cmult <= sum[ACC_WIDTH-1:0];
                    Ovf   <= Ovf | add_ovf;
                end
            end
        end
    end

endmodule
